openram_scan_master: RTL and testbench

//  Host-side driver for the OpenRAM testchip GPIO scan port; the transmitter matching the chip's scan receiver.

---
 rtl/openram_scan_master.sv | 189 ++++++++++++++++++
 tb/tb_openram_scan_master.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openram_scan_master.sv
// openram_scan_master: serialises one command packet into the OpenRAM testchip
// scan chain, optionally pulses sram_load, and returns the bits shifted out.
//
// Ports:
//   clk, resetn        system clock, synchronous active-low reset
//   cmd_valid/ready    command handshake; cmd_data shifted MSB first,
//                      cmd_load selects an sram_load pulse after the shift
//   rsp_valid/ready    response handshake; rsp_data holds the captured chain,
//                      first captured bit in the MSB
//   tc_clk, tc_scan    chip gpio_clk / gpio_scan
//   tc_sram_load       chip gpio_sram_load
//   tc_csb             chip global_csb (active-low)
//   tc_sdi, tc_sdo     serial data to / from the chip
module openram_scan_master #(
    parameter int PKT_W    = 112,
    parameter int CLK_DIV  = 2,
    parameter int LOAD_CYC = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [PKT_W-1:0] cmd_data,
    input  logic             cmd_load,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [PKT_W-1:0] rsp_data,
    output logic             tc_clk,
    output logic             tc_scan,
    output logic             tc_sram_load,
    output logic             tc_csb,
    output logic             tc_sdi,
    input  logic             tc_sdo
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(PKT_W + 1);
    localparam int LD_W  = $clog2(LOAD_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt, div_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_nxt;
    logic [LD_W-1:0]    ld_cnt, ld_cnt_nxt;
    // MSB of the packet already sits on tc_sdi, so only the rest is kept.
    logic [PKT_W-2:0]   tx_sr, tx_nxt;
    logic [PKT_W-1:0]   rx_sr, rx_nxt;
    logic [PKT_W-1:0]   rsp_data_nxt;
    logic               load_flag, load_flag_nxt;
    logic               clk_nxt;
    logic               scan_nxt;
    logic               sram_load_nxt;
    logic               csb_nxt;
    logic               sdi_nxt;
    logic               cmd_ready_nxt;
    logic               rsp_valid_nxt;
    logic               running;
    logic               tick;
    logic               rise;
    logic               fall;

    assign running = (state == SHIFT) || (state == LOAD);
    assign tick    = running && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise    = tick && !tc_clk;
    assign fall    = tick && tc_clk;

    always_comb begin
        state_nxt     = state;
        div_nxt       = '0;
        clk_nxt       = 1'b0;
        bit_nxt       = bit_cnt;
        ld_cnt_nxt    = ld_cnt;
        tx_nxt        = tx_sr;
        rx_nxt        = rx_sr;
        rsp_data_nxt  = rsp_data;
        load_flag_nxt = load_flag;
        scan_nxt      = tc_scan;
        sram_load_nxt = tc_sram_load;
        csb_nxt       = tc_csb;
        sdi_nxt       = tc_sdi;
        cmd_ready_nxt = cmd_ready;
        rsp_valid_nxt = rsp_valid;

        if (running) begin
            div_nxt = tick ? '0 : div_cnt + DIV_W'(1);
            clk_nxt = tick ? ~tc_clk : tc_clk;
        end

        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nxt     = SHIFT;
                    tx_nxt        = cmd_data[PKT_W-2:0];
                    load_flag_nxt = cmd_load;
                    bit_nxt       = CNT_W'(PKT_W);
                    scan_nxt      = 1'b1;
                    sdi_nxt       = cmd_data[PKT_W-1];
                    cmd_ready_nxt = 1'b0;
                end
            end
            SHIFT: begin
                if (rise) begin
                    rx_nxt  = {rx_sr[PKT_W-2:0], tc_sdo};
                    bit_nxt = bit_cnt - CNT_W'(1);
                end else if (fall) begin
                    if (bit_cnt != '0) begin
                        tx_nxt  = {tx_sr[PKT_W-3:0], 1'b0};
                        sdi_nxt = tx_sr[PKT_W-2];
                    end else begin
                        scan_nxt = 1'b0;
                        sdi_nxt  = 1'b0;
                        if (load_flag) begin
                            state_nxt     = LOAD;
                            sram_load_nxt = 1'b1;
                            csb_nxt       = 1'b0;
                            ld_cnt_nxt    = '0;
                        end else begin
                            state_nxt     = DONE;
                            rsp_valid_nxt = 1'b1;
                            rsp_data_nxt  = rx_sr;
                        end
                    end
                end
            end
            LOAD: begin
                if (rise) begin
                    ld_cnt_nxt = ld_cnt + LD_W'(1);
                end else if (fall && ld_cnt == LD_W'(LOAD_CYC)) begin
                    state_nxt     = DONE;
                    sram_load_nxt = 1'b0;
                    csb_nxt       = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = rx_sr;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            ld_cnt       <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            rsp_data     <= '0;
            load_flag    <= 1'b0;
            tc_clk       <= 1'b0;
            tc_scan      <= 1'b0;
            tc_sram_load <= 1'b0;
            tc_csb       <= 1'b1;
            tc_sdi       <= 1'b0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
        end else begin
            state        <= state_nxt;
            div_cnt      <= div_nxt;
            bit_cnt      <= bit_nxt;
            ld_cnt       <= ld_cnt_nxt;
            tx_sr        <= tx_nxt;
            rx_sr        <= rx_nxt;
            rsp_data     <= rsp_data_nxt;
            load_flag    <= load_flag_nxt;
            tc_clk       <= clk_nxt;
            tc_scan      <= scan_nxt;
            tc_sram_load <= sram_load_nxt;
            tc_csb       <= csb_nxt;
            tc_sdi       <= sdi_nxt;
            cmd_ready    <= cmd_ready_nxt;
            rsp_valid    <= rsp_valid_nxt;
        end
    end

endmodule

// File: tb/tb_openram_scan_master.sv
// tb_openram_scan_master: two scan masters (8-bit/div 2 and 112-bit/div 1)
// each driving a shift-register chip model, checked against a timeline model.
module tb_openram_scan_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit cmp_on = 1'b0;

    always @(posedge clk) cyc++;

    logic         a_resetn, a_cmd_valid, a_cmd_ready, a_cmd_load;
    logic         a_rsp_valid, a_rsp_ready;
    logic         a_tc_clk, a_tc_scan, a_tc_sram_load, a_tc_csb;
    logic         a_tc_sdi, a_tc_sdo;
    logic [7:0]   a_cmd_data, a_rsp_data;

    logic         b_resetn, b_cmd_valid, b_cmd_ready, b_cmd_load;
    logic         b_rsp_valid, b_rsp_ready;
    logic         b_tc_clk, b_tc_scan, b_tc_sram_load, b_tc_csb;
    logic         b_tc_sdi, b_tc_sdo;
    logic [111:0] b_cmd_data, b_rsp_data;

    openram_scan_master #(
        .PKT_W(8), .CLK_DIV(2), .LOAD_CYC(2)
    ) u_dut_a (
        .clk(clk), .resetn(a_resetn),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_data(a_cmd_data), .cmd_load(a_cmd_load),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_data(a_rsp_data),
        .tc_clk(a_tc_clk), .tc_scan(a_tc_scan),
        .tc_sram_load(a_tc_sram_load), .tc_csb(a_tc_csb),
        .tc_sdi(a_tc_sdi), .tc_sdo(a_tc_sdo)
    );

    openram_scan_master #(
        .PKT_W(112), .CLK_DIV(1), .LOAD_CYC(2)
    ) u_dut_b (
        .clk(clk), .resetn(b_resetn),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_data(b_cmd_data), .cmd_load(b_cmd_load),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data),
        .tc_clk(b_tc_clk), .tc_scan(b_tc_scan),
        .tc_sram_load(b_tc_sram_load), .tc_csb(b_tc_csb),
        .tc_sdi(b_tc_sdi), .tc_sdo(b_tc_sdo)
    );

    // Chip models: a plain shift chain clocked by gpio_clk while gpio_scan is high.
    logic [7:0]   chain_a = '0;
    logic [111:0] chain_b = '0;
    logic [7:0]   sdi_log_a = '0;
    int rise_scan_a = 0, rise_load_a = 0;
    int rise_scan_b = 0, rise_load_b = 0;

    assign a_tc_sdo = chain_a[7];
    assign b_tc_sdo = chain_b[111];

    always @(posedge a_tc_clk) begin
        if (a_tc_scan) begin
            chain_a = {chain_a[6:0], a_tc_sdi};
            sdi_log_a = {sdi_log_a[6:0], a_tc_sdi};
            rise_scan_a++;
        end
        if (a_tc_sram_load) rise_load_a++;
    end

    always @(posedge b_tc_clk) begin
        if (b_tc_scan) begin
            chain_b = {chain_b[110:0], b_tc_sdi};
            rise_scan_b++;
        end
        if (b_tc_sram_load) rise_load_b++;
    end

    // Timeline model: a transaction is just "k cycles since acceptance";
    // every output is a closed-form function of k and the latched command.
    typedef struct {
        int           mode;   // 0 idle, 1 busy, 2 response pending
        int           k;
        logic [111:0] cur;
        bit           ld;
        logic [111:0] rsp;
        logic [111:0] prev;   // chain contents the chip will shift out next
        int           p;
        int           d;
        int           l;
    } mdl_t;

    typedef struct {
        bit           ready;
        bit           valid;
        bit           tclk;
        bit           scan;
        bit           sload;
        bit           csb;
        bit           sdi;
        logic [111:0] data;
    } obs_t;

    mdl_t m[2];

    function automatic mdl_t step(mdl_t s, bit rst_n, bit v,
                                 logic [111:0] d, bit ld, bit rdy);
        mdl_t n = s;
        int total;
        total = 2 * s.p * s.d + (s.ld ? 2 * s.l * s.d : 0);
        if (!rst_n) begin
            n.mode = 0;
            n.rsp  = '0;
        end else if (s.mode == 0) begin
            if (v) begin
                n.mode = 1;
                n.k    = 0;
                n.cur  = d;
                n.ld   = ld;
            end
        end else if (s.mode == 1) begin
            n.k = s.k + 1;
            if (n.k == total) begin
                n.mode = 2;
                n.rsp  = s.prev;
                n.prev = s.cur;
            end
        end else if (rdy) begin
            n.mode = 0;
        end
        return n;
    endfunction

    function automatic obs_t exp_out(mdl_t s);
        obs_t o;
        int sh;
        sh = 2 * s.p * s.d;
        o.ready = 1'b0; o.valid = 1'b0; o.tclk = 1'b0; o.scan = 1'b0;
        o.sload = 1'b0; o.csb = 1'b1; o.sdi = 1'b0; o.data = s.rsp;
        if (s.mode == 0) begin
            o.ready = 1'b1;
        end else if (s.mode == 2) begin
            o.valid = 1'b1;
        end else if (s.k < sh) begin
            o.tclk = ((s.k / s.d) % 2) == 1;
            o.scan = 1'b1;
            o.sdi  = s.cur[s.p - 1 - s.k / (2 * s.d)];
        end else begin
            o.tclk  = (((s.k - sh) / s.d) % 2) == 1;
            o.sload = 1'b1;
            o.csb   = 1'b0;
        end
        return o;
    endfunction

    task automatic chk(input string u, input string f,
                       input logic [111:0] got, input logic [111:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s got=%0h exp=%0h cycle=%0d",
                     u, f, got, exp, cyc);
        end
    endtask

    task automatic chk_obs(input string u, input obs_t g, input obs_t e);
        chk(u, "cmd_ready", g.ready, e.ready);
        chk(u, "rsp_valid", g.valid, e.valid);
        chk(u, "tc_clk", g.tclk, e.tclk);
        chk(u, "tc_scan", g.scan, e.scan);
        chk(u, "tc_sram_load", g.sload, e.sload);
        chk(u, "tc_csb", g.csb, e.csb);
        chk(u, "tc_sdi", g.sdi, e.sdi);
        chk(u, "rsp_data", g.data, e.data);
    endtask

    initial begin
        m[0].mode = 0; m[0].k = 0; m[0].cur = '0; m[0].ld = 0;
        m[0].rsp = '0; m[0].prev = '0; m[0].p = 8; m[0].d = 2; m[0].l = 2;
        m[1].mode = 0; m[1].k = 0; m[1].cur = '0; m[1].ld = 0;
        m[1].rsp = '0; m[1].prev = '0; m[1].p = 112; m[1].d = 1; m[1].l = 2;
    end

    always @(posedge clk) begin
        m[0] = step(m[0], a_resetn, a_cmd_valid, 112'(a_cmd_data),
                    a_cmd_load, a_rsp_ready);
        m[1] = step(m[1], b_resetn, b_cmd_valid, b_cmd_data,
                    b_cmd_load, b_rsp_ready);
    end

    always @(negedge clk) begin : cmp_blk
        obs_t ga;
        obs_t gb;
        if (cmp_on) begin
            ga.ready = a_cmd_ready; ga.valid = a_rsp_valid;
            ga.tclk = a_tc_clk; ga.scan = a_tc_scan;
            ga.sload = a_tc_sram_load; ga.csb = a_tc_csb;
            ga.sdi = a_tc_sdi; ga.data = 112'(a_rsp_data);
            chk_obs("a", ga, exp_out(m[0]));
            gb.ready = b_cmd_ready; gb.valid = b_rsp_valid;
            gb.tclk = b_tc_clk; gb.scan = b_tc_scan;
            gb.sload = b_tc_sram_load; gb.csb = b_tc_csb;
            gb.sdi = b_tc_sdi; gb.data = b_rsp_data;
            chk_obs("b", gb, exp_out(m[1]));
        end
    end

    task automatic load_chain_a(input logic [7:0] v);
        chain_a = v;
        m[0].prev = 112'(v);
    endtask

    task automatic send_a(input logic [7:0] d, input bit ld);
        a_cmd_data  = d;
        a_cmd_load  = ld;
        a_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        a_cmd_data  = 8'($urandom);
        a_cmd_load  = 1'($urandom);
    endtask

    task automatic wait_rsp_a(input string nm, input logic [7:0] exp,
                              input int hold, input bit noise,
                              output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (a_rsp_valid) begin
                lat = i;
                break;
            end
            if (noise) begin
                a_cmd_valid = 1'($urandom);
                a_cmd_data  = 8'($urandom);
                a_cmd_load  = 1'($urandom);
            end
        end
        chk(nm, "rsp_timeout", lat < 0, 1'b0);
        chk(nm, "rsp_data", a_rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (noise) begin
                a_cmd_valid = 1'($urandom);
                a_cmd_data  = 8'($urandom);
            end
        end
        a_cmd_valid = 1'b0;
        if (hold > 0) begin
            chk(nm, "held_valid", a_rsp_valid, 1'b1);
            chk(nm, "held_data", a_rsp_data, exp);
            chk(nm, "held_ready", a_cmd_ready, 1'b0);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b0;
        @(negedge clk);
        chk(nm, "post_valid", a_rsp_valid, 1'b0);
        chk(nm, "post_ready", a_cmd_ready, 1'b1);
    endtask

    task automatic send_b(input logic [111:0] d, input bit ld);
        b_cmd_data  = d;
        b_cmd_load  = ld;
        b_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        b_cmd_valid = 1'b0;
        b_cmd_data  = '0;
    endtask

    task automatic wait_rsp_b(input string nm, input logic [111:0] exp,
                              output int lat);
        lat = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (b_rsp_valid) begin
                lat = i;
                break;
            end
        end
        chk(nm, "rsp_timeout", lat < 0, 1'b0);
        chk(nm, "rsp_data", b_rsp_data, exp);
        @(negedge clk);
        chk(nm, "post_valid", b_rsp_valid, 1'b0);
        chk(nm, "post_ready", b_cmd_ready, 1'b1);
    endtask

    function automatic logic [111:0] rnd112();
        return 112'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int vcount;
        logic [7:0]   da, shadow_a;
        logic [111:0] db, shadow_b;
        bit ld;

        a_resetn = 1'b0; b_resetn = 1'b0;
        a_cmd_valid = 1'b0; a_cmd_data = '0; a_cmd_load = 1'b0;
        a_rsp_ready = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_data = '0; b_cmd_load = 1'b0;
        b_rsp_ready = 1'b1;

        @(posedge clk);
        #1 cmp_on = 1'b1;
        @(posedge clk);
        #1;
        a_resetn = 1'b1;
        b_resetn = 1'b1;
        @(negedge clk);
        chk("reset", "a_cmd_ready", a_cmd_ready, 1'b1);
        chk("reset", "a_tc_csb", a_tc_csb, 1'b1);
        chk("reset", "a_rsp_data", a_rsp_data, 8'h00);
        chk("reset", "b_cmd_ready", b_cmd_ready, 1'b1);

        // 1: shift-only, chip shifts out 0x3C
        load_chain_a(8'h3C);
        rise_scan_a = 0; rise_load_a = 0; sdi_log_a = '0;
        send_a(8'hA5, 1'b0);
        wait_rsp_a("t1", 8'h3C, 0, 1'b0, lat);
        chk("t1", "latency", lat, 32);
        chk("t1", "scan_rises", rise_scan_a, 8);
        chk("t1", "sdi_seq", sdi_log_a, 8'b1010_0101);
        chk("t1", "load_rises", rise_load_a, 0);

        // 2: same packet with sram_load; chain now holds 0xA5
        rise_scan_a = 0; rise_load_a = 0;
        send_a(8'hA5, 1'b1);
        wait_rsp_a("t2", 8'hA5, 0, 1'b0, lat);
        chk("t2", "latency", lat, 40);
        chk("t2", "scan_rises", rise_scan_a, 8);
        chk("t2", "load_rises", rise_load_a, 2);

        // 3: full duplex through a cleared chain
        load_chain_a(8'h00);
        send_a(8'h11, 1'b0);
        wait_rsp_a("t3a", 8'h00, 0, 1'b0, lat);
        send_a(8'h22, 1'b0);
        wait_rsp_a("t3b", 8'h11, 0, 1'b0, lat);

        // 4: response held 10 cycles, stray commands ignored
        send_a(8'h5A, 1'b0);
        wait_rsp_a("t4", 8'h22, 10, 1'b1, lat);

        // 5: reset after the third rise drops the transaction
        rise_scan_a = 0;
        send_a(8'hF0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rise_scan_a >= 3) break;
        end
        chk("t5", "third_rise", rise_scan_a, 3);
        a_resetn = 1'b0;
        @(posedge clk);
        #1 a_resetn = 1'b1;
        @(negedge clk);
        chk("t5", "tc_scan", a_tc_scan, 1'b0);
        chk("t5", "tc_clk", a_tc_clk, 1'b0);
        chk("t5", "tc_csb", a_tc_csb, 1'b1);
        chk("t5", "tc_sdi", a_tc_sdi, 1'b0);
        chk("t5", "cmd_ready", a_cmd_ready, 1'b1);
        vcount = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (a_rsp_valid) vcount++;
        end
        chk("t5", "no_rsp", vcount, 0);

        // random traffic on the 8-bit master
        shadow_a = 8'($urandom);
        load_chain_a(shadow_a);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            da = 8'($urandom);
            ld = 1'($urandom);
            send_a(da, ld);
            wait_rsp_a("rnd", shadow_a, $urandom_range(0, 3), 1'b1, lat);
            chk("rnd", "latency", lat, ld ? 40 : 32);
            shadow_a = da;
        end

        // 6: 112-bit packets, divider 1, rsp_ready held high
        shadow_b = rnd112();
        chain_b = shadow_b;
        m[1].prev = shadow_b;
        for (int i = 0; i < 4; i++) begin
            db = rnd112();
            ld = (i == 1) ? 1'b1 : ((i == 0) ? 1'b0 : 1'($urandom));
            rise_scan_b = 0;
            rise_load_b = 0;
            send_b(db, ld);
            wait_rsp_b("t6", shadow_b, lat);
            chk("t6", "latency", lat, ld ? 228 : 224);
            chk("t6", "scan_rises", rise_scan_b, 112);
            chk("t6", "load_rises", rise_load_b, ld ? 2 : 0);
            shadow_b = db;
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
